collatz_core: RTL and testbench
===============================

// Module: collatz_core
// PURPOSE
//   Iterative Collatz trajectory engine, instantiated by tt_um_rtfb_collatz.
//   Top wrapper assembles a start value from ui_in/uio_in, hands it in over a
//   valid/ready port, and drives uo_out from the result: step count to 1 and
//   peak trajectory value. One Collatz step per clock; error flag on overflow.
// PARAMETERS
//   WIDTH  16  bit width of start value, working value and peak
//   STEPW   8  bit width of step counter (saturating)
// PORTS
//   clk           in   1      clock, all logic on rising edge
//   rst           in   1      synchronous reset, active high
//   start_valid   in   1      start_value valid
//   start_ready   out  1      core idle, accepts start_value
//   start_value   in   WIDTH  trajectory seed n0
//   res_valid     out  1      result fields valid, held until taken
//   res_ready     in   1      consumer takes result
//   res_steps     out  STEPW  steps taken to reach 1 (saturates at 2^STEPW-1)
//   res_peak      out  WIDTH  max value reached (includes n0)
//   res_err       out  1      n0==0, or 3n+1 exceeded WIDTH bits
//   busy          out  1      state==RUN
// BEHAVIOUR
//   - Reset: state IDLE; start_ready=1; res_valid=0, res_steps=0, res_peak=0,
//     res_err=0, busy=0; rst overrides every other input, same edge.
//   - FSM IDLE -> RUN -> DONE -> IDLE. start_ready = (state==IDLE).
//   - IDLE: on start_valid&&start_ready latch n=start_value, peak=start_value,
//     steps=0, err=0; n0==0 -> DONE with err=1, steps 0, peak 0; else -> RUN.
//   - RUN, per cycle, priority order:
//       n==1            -> DONE (no update)
//       n even          -> n=n>>1, steps+=1
//       n odd           -> t=3n+1 in WIDTH+2 bits; t[WIDTH+1:WIDTH]!=0 -> DONE,
//                          err=1, n/steps/peak unchanged; else n=t, steps+=1,
//                          peak=max(peak,t)
//   - Latency: accept edge + 1 RUN cycle per step + 1 terminal RUN cycle;
//     res_valid rises steps+2 cycles after the accept edge (standard mode).
//   - DONE: res_valid=1, res_* stable; res_ready -> IDLE next edge. res_valid
//     low in IDLE/RUN; res_* keep last values until next accept.
//   - steps saturates at all-ones, iteration continues; no flag.
//   - start_valid while RUN/DONE ignored (ready low); no queueing.
//   - rst mid-RUN or in DONE: result discarded, back to IDLE, outputs as reset.
//   - Peak only grows on odd steps (halving never exceeds current n).
// CONFIGURATION
//   COLLATZ_SHORTCUT_EN defined: odd step computes t=3n+1, n=t>>1, steps+=2
//     (saturating), peak=max(peak,t); overflow test still on t. Even/terminal
//     handling unchanged. res_steps/res_peak/res_err identical to standard
//     mode; only latency shrinks (one cycle per odd step saved).
//   Undefined: one step per cycle as above.
// TESTING
//   - n0=1 -> res_valid 2 cycles after accept; steps=0, peak=1, err=0.
//   - n0=6 -> steps=8, peak=16, err=0; res_valid 10 cycles after accept
//     (standard mode).
//   - n0=27 -> steps=111, peak=9232, err=0 in both macro settings; shortcut
//     build shows strictly lower latency.
//   - n0=0 -> steps=0, peak=0, err=1; n0=65535 -> err=1, steps=0, peak=65535.
//   - Hold res_ready=0 10 cycles at DONE -> res_* stable, start_ready=0,
//     start_valid pulses ignored; then res_ready=1 -> IDLE, next seed n0=7
//     gives steps=16, peak=52.
//   - rst=1 one cycle mid-RUN of n0=27 -> IDLE, reset values next edge;
//     follow-up n0=6 gives steps=8, peak=16.

Source files
------------

// File: rtl/collatz_if.sv
// Start/result handshake bundle for collatz_core: seed in over valid/ready,
// result fields out over valid/ready.
interface collatz_if #(
  parameter int WIDTH = 16,
  parameter int STEPW = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] start_value;
  logic             res_valid;
  logic             res_ready;
  logic [STEPW-1:0] res_steps;
  logic [WIDTH-1:0] res_peak;
  logic             res_err;

  modport master (
    output start_valid, start_value, res_ready,
    input  start_ready, res_valid, res_steps, res_peak, res_err
  );

  modport slave (
    input  start_valid, start_value, res_ready,
    output start_ready, res_valid, res_steps, res_peak, res_err
  );
endinterface

// File: rtl/collatz_core.sv
// Iterative Collatz trajectory engine: steps to reach 1, peak value, overflow error.
// Optional macro COLLATZ_SHORTCUT_EN folds each odd step with the following halving.
module collatz_core #(
  parameter int WIDTH = 16,
  parameter int STEPW = 8
) (
  input  logic       clk,
  input  logic       rst,
  collatz_if.slave   bus,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] n_r, n_nx_s;
  logic [STEPW-1:0] steps_r, steps_nx_s;
  logic [WIDTH-1:0] peak_r, peak_nx_s;
  logic             err_r, err_nx_s;
  logic [WIDTH+1:0] t_s;
  logic             ovf_s;

  logic             start_ready_r;
  logic             res_valid_r;
  logic             busy_r;
  logic [STEPW-1:0] res_steps_r;
  logic [WIDTH-1:0] res_peak_r;
  logic             res_err_r;

  // Step counter add that sticks at all-ones instead of wrapping.
  function automatic logic [STEPW-1:0] sat_add(input logic [STEPW-1:0] v,
                                               input logic [1:0] inc);
    logic [STEPW:0] sum;
    sum = {1'b0, v} + {{(STEPW-1){1'b0}}, inc};
    if (sum[STEPW]) begin
      sat_add = {STEPW{1'b1}};
    end else begin
      sat_add = sum[STEPW-1:0];
    end
  endfunction

  // 3n+1 kept two bits wider so any carry out of WIDTH is visible.
  always_comb begin
    t_s   = {1'b0, n_r, 1'b0} + {2'b00, n_r} + {{(WIDTH+1){1'b0}}, 1'b1};
    ovf_s = (t_s[WIDTH+1:WIDTH] != 2'b00);
  end

  // Next-state and working-register update.
  always_comb begin
    state_nx_s = state_r;
    n_nx_s     = n_r;
    steps_nx_s = steps_r;
    peak_nx_s  = peak_r;
    err_nx_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_valid) begin
          n_nx_s     = bus.start_value;
          peak_nx_s  = bus.start_value;
          steps_nx_s = {STEPW{1'b0}};
          err_nx_s   = 1'b0;
          if (bus.start_value == {WIDTH{1'b0}}) begin
            err_nx_s   = 1'b1;
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (n_r == {{(WIDTH-1){1'b0}}, 1'b1}) begin
          state_nx_s = ST_DONE;
        end else if (!n_r[0]) begin
          n_nx_s     = n_r >> 1;
          steps_nx_s = sat_add(steps_r, 2'd1);
        end else if (ovf_s) begin
          // Overflowing step is not taken: n, steps and peak stay as they were.
          err_nx_s   = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
`ifdef COLLATZ_SHORTCUT_EN
          // 3n+1 is always even, so its halving is merged into this cycle.
          n_nx_s     = t_s[WIDTH:1];
          steps_nx_s = sat_add(steps_r, 2'd2);
`else
          n_nx_s     = t_s[WIDTH-1:0];
          steps_nx_s = sat_add(steps_r, 2'd1);
`endif
          if (t_s[WIDTH-1:0] > peak_r) begin
            peak_nx_s = t_s[WIDTH-1:0];
          end else begin
            peak_nx_s = peak_r;
          end
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      n_r     <= {WIDTH{1'b0}};
      steps_r <= {STEPW{1'b0}};
      peak_r  <= {WIDTH{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      n_r     <= n_nx_s;
      steps_r <= steps_nx_s;
      peak_r  <= peak_nx_s;
      err_r   <= err_nx_s;
    end
  end

  // Handshake flags registered from the next state so they track state_r exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_ready_r <= 1'b1;
      res_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      start_ready_r <= (state_nx_s == ST_IDLE);
      res_valid_r   <= (state_nx_s == ST_DONE);
      busy_r        <= (state_nx_s == ST_RUN);
    end
  end

  // Result fields captured on entry to DONE and held until the next result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_steps_r <= {STEPW{1'b0}};
      res_peak_r  <= {WIDTH{1'b0}};
      res_err_r   <= 1'b0;
    end else if ((state_r != ST_DONE) && (state_nx_s == ST_DONE)) begin
      res_steps_r <= steps_nx_s;
      res_peak_r  <= peak_nx_s;
      res_err_r   <= err_nx_s;
    end else begin
      res_steps_r <= res_steps_r;
      res_peak_r  <= res_peak_r;
      res_err_r   <= res_err_r;
    end
  end

  assign bus.start_ready = start_ready_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_steps   = res_steps_r;
  assign bus.res_peak    = res_peak_r;
  assign bus.res_err     = res_err_r;
  assign busy            = busy_r;

endmodule

// File: tb/tb_collatz_core.sv
// Randomized self-checking bench for collatz_core against an arithmetic Collatz model.
module tb_collatz_core;

  logic clk;
  logic rst;
  logic busy;
  int   errors;
  int   checks;

  collatz_if #(.WIDTH(16), .STEPW(8)) bus ();

  collatz_core #(.WIDTH(16), .STEPW(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk the trajectory with wide integers.
  task automatic model(input int n0, output int steps, output int peak, output int err,
                       output int lat);
    longint n;
    longint t;
    int     raw;
    int     odds;
    raw  = 0;
    odds = 0;
    err  = 0;
    if (n0 == 0) begin
      steps = 0;
      peak  = 0;
      err   = 1;
      lat   = 1;
      return;
    end
    n    = n0;
    peak = n0;
    while (n != 1 && raw < 100000) begin
      if (n % 2 == 0) begin
        n = n / 2;
        raw++;
      end else begin
        t = 3 * n + 1;
        if (t > 65535) begin
          err = 1;
          break;
        end
        n = t;
        raw++;
        odds++;
        if (t > peak) peak = int'(t);
      end
    end
    steps = (raw > 255) ? 255 : raw;
`ifdef COLLATZ_SHORTCUT_EN
    lat = raw - odds + 2;
`else
    lat = raw + 2;
`endif
  endtask

  // Present one seed, measure edges to res_valid (accept edge counts as 1), check result.
  task automatic run_seed(input int n0, input bit take);
    int es, ep, ee, el, cnt;
    model(n0, es, ep, ee, el);
    @(negedge clk);
    check_eq("start_ready_idle", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.start_value = 16'(n0);
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    check_eq("busy_after_accept", 32'(busy), (n0 != 0) ? 32'd1 : 32'd0);
    while (!bus.res_valid && cnt < 3000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check_eq("latency", 32'(cnt), 32'(el));
    check_eq("res_steps", 32'(bus.res_steps), 32'(es));
    check_eq("res_peak", 32'(bus.res_peak), 32'(ep));
    check_eq("res_err", 32'(bus.res_err), 32'(ee));
    check_eq("start_ready_done", 32'(bus.start_ready), 32'd0);
    if (take) begin
      bus.res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.res_ready = 1'b0;
      check_eq("res_valid_taken", 32'(bus.res_valid), 32'd0);
      check_eq("start_ready_back", 32'(bus.start_ready), 32'd1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.start_ready), 32'd1);
    check_eq({tag, "_valid"}, 32'(bus.res_valid), 32'd0);
    check_eq({tag, "_steps"}, 32'(bus.res_steps), 32'd0);
    check_eq({tag, "_peak"}, 32'(bus.res_peak), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.res_err), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    errors          = 0;
    checks          = 0;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.start_value = 16'd0;
    bus.res_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    run_seed(1, 1'b1);
    check_eq("n1_steps_const", 32'(bus.res_steps), 32'd0);
    check_eq("n1_peak_const", 32'(bus.res_peak), 32'd1);
    run_seed(6, 1'b1);
    check_eq("n6_steps_const", 32'(bus.res_steps), 32'd8);
    check_eq("n6_peak_const", 32'(bus.res_peak), 32'd16);
    run_seed(0, 1'b1);
    check_eq("n0_err_const", 32'(bus.res_err), 32'd1);
    run_seed(65535, 1'b1);
    check_eq("nmax_err_const", 32'(bus.res_err), 32'd1);
    check_eq("nmax_peak_const", 32'(bus.res_peak), 32'd65535);

    // Result held under back-pressure; new seeds refused meanwhile.
    run_seed(27, 1'b0);
    check_eq("n27_steps_const", 32'(bus.res_steps), 32'd111);
    check_eq("n27_peak_const", 32'(bus.res_peak), 32'd9232);
    for (int i = 0; i < 10; i++) begin
      bus.start_valid = i[0];
      bus.start_value = 16'd5;
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.res_valid), 32'd1);
      check_eq("hold_steps", 32'(bus.res_steps), 32'd111);
      check_eq("hold_peak", 32'(bus.res_peak), 32'd9232);
      check_eq("hold_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_eq("release_ready", 32'(bus.start_ready), 32'd1);
    run_seed(7, 1'b1);
    check_eq("n7_steps_const", 32'(bus.res_steps), 32'd16);
    check_eq("n7_peak_const", 32'(bus.res_peak), 32'd52);

    // Reset in the middle of a run discards everything.
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_value = 16'd27;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midrun_rst");
    run_seed(6, 1'b1);
    check_eq("post_rst_steps", 32'(bus.res_steps), 32'd8);
    check_eq("post_rst_peak", 32'(bus.res_peak), 32'd16);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) n0 = int'($urandom_range(1, 400));
      else n0 = int'($urandom_range(0, 65535));
      run_seed(n0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
